// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone add/subtract unit with a global-stall valid/ready handshake.
// Prefix levels are grouped PIPE_EVERY per register stage; the last stage holds sum/cout/ovf.
module ks_adder_pipe #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PIPE_EVERY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned LEVELS = $clog2(WIDTH);
  localparam int unsigned NSTG   = (LEVELS + PIPE_EVERY - 1) / PIPE_EVERY;

  function automatic logic [WIDTH-1:0] pfx_g(input logic [WIDTH-1:0] g,
                                             input logic [WIDTH-1:0] p,
                                             input int unsigned      s);
    logic [WIDTH-1:0] r;
    r = g;
    for (int unsigned i = s; i < WIDTH; i++) r[i] = g[i] | (p[i] & g[i-s]);
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] pfx_p(input logic [WIDTH-1:0] p,
                                             input int unsigned      s);
    logic [WIDTH-1:0] r;
    r = p;
    for (int unsigned i = s; i < WIDTH; i++) r[i] = p[i] & p[i-s];
    return r;
  endfunction

  logic             en;
  logic [WIDTH-1:0] b_eff, g_in, p_in, sum_d;
  logic             c0;

  // Stage j holds the prefix state after j*PIPE_EVERY levels.
  logic [WIDTH-1:0] st_g_q  [NSTG];
  logic [WIDTH-1:0] st_p_q  [NSTG];
  logic [WIDTH-1:0] st_po_q [NSTG];
  logic             st_c0_q [NSTG];
  logic             st_v_q  [NSTG];

  logic [WIDTH-1:0] lo_g [1:LEVELS];
  logic [WIDTH-1:0] lo_p [1:LEVELS];

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  always_comb begin
    b_eff   = sub ? ~b : b;
    c0      = sub ? ~cin : cin;
    p_in    = a ^ b_eff;
    g_in    = a & b_eff;
    g_in[0] = g_in[0] | (p_in[0] & c0);
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int unsigned Span = 1 << (k - 1);
    logic [WIDTH-1:0] gi, pi;
    if (((k - 1) % PIPE_EVERY) == 0) begin : g_from_reg
      assign gi = st_g_q[(k-1)/PIPE_EVERY];
      assign pi = st_p_q[(k-1)/PIPE_EVERY];
    end else begin : g_from_comb
      assign gi = lo_g[k-1];
      assign pi = lo_p[k-1];
    end
    assign lo_g[k] = pfx_g(gi, pi, Span);
    assign lo_p[k] = pfx_p(pi, Span);
  end

  // Carry into bit i is the group generate of bits [i-1:0], c0 already folded in.
  always_comb begin
    sum_d    = '0;
    sum_d[0] = st_po_q[NSTG-1][0] ^ st_c0_q[NSTG-1];
    for (int unsigned i = 1; i < WIDTH; i++) sum_d[i] = st_po_q[NSTG-1][i] ^ lo_g[LEVELS][i-1];
  end

  // Data registers only load behind a valid beat so outputs stay 0 until the first result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NSTG; j++) begin
        st_v_q[j]  <= 1'b0;
        st_g_q[j]  <= '0;
        st_p_q[j]  <= '0;
        st_po_q[j] <= '0;
        st_c0_q[j] <= 1'b0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      st_v_q[0] <= in_valid;
      if (in_valid) begin
        st_g_q[0]  <= g_in;
        st_p_q[0]  <= p_in;
        st_po_q[0] <= p_in;
        st_c0_q[0] <= c0;
      end
      for (int j = 1; j < NSTG; j++) begin
        st_v_q[j] <= st_v_q[j-1];
        if (st_v_q[j-1]) begin
          st_g_q[j]  <= lo_g[j*PIPE_EVERY];
          st_p_q[j]  <= lo_p[j*PIPE_EVERY];
          st_po_q[j] <= st_po_q[j-1];
          st_c0_q[j] <= st_c0_q[j-1];
        end
      end
      out_valid <= st_v_q[NSTG-1];
      if (st_v_q[NSTG-1]) begin
        sum  <= sum_d;
        cout <= lo_g[LEVELS][WIDTH-1];
        ovf  <= lo_g[LEVELS][WIDTH-2] ^ lo_g[LEVELS][WIDTH-1];
      end
    end
  end

endmodule
